garage_lane_sensor: RTL
=======================

# garage_lane_sensor

Upstream stage of the garage occupancy counter. The block watches one bidirectional lane fitted with two light-beam sensors, A (street side) and B (garage side). It synchronises and debounces both beams and classifies each vehicle passage as entry or exit. For each completed passage it drives exactly one single-cycle `increment` or `decrement` pulse into the occupancy counter. It also drives the barrier (`gate_open`) and refuses entry while the counter reports full.

## Interface
- `DEBOUNCE`, default 4: consecutive stable cycles a synchronised beam value must hold before the debounced value changes.
- `TIMEOUT`, default 1000: cycles allowed without a state change in any active state before the passage is aborted.
- `MAX_CARS`, default 50: garage capacity. Documentation only; `full` and `empty` come from the counter.

Ports:
- `clk`, input, 1: single clock. All logic is rising-edge.
- `reset`, input, 1: synchronous, active-low. Sampled on the `clk` rising edge; `reset`==0 resets the block.
- `sensor_a`, input, 1: raw beam A, 1 = beam broken. Asynchronous.
- `sensor_b`, input, 1: raw beam B, 1 = beam broken. Asynchronous.
- `full`, input, 1: counter at `MAX_CARS`. Synchronous to `clk`.
- `empty`, input, 1: counter at 0. Synchronous to `clk`.
- `increment`, output, 1: one-cycle pulse, one car entered.
- `decrement`, output, 1: one-cycle pulse, one car left.
- `gate_open`, output, 1: barrier raise command.
- `denied`, output, 1: entry refused because the garage is full.

## Operation
- Reset (`reset`==0 at a clock edge): state goes to IDLE; synchroniser and debounce registers clear to 0; debounce and timeout counters clear to 0; all four outputs go to 0.
- Each beam path: 2-flop synchroniser, then the debouncer. The debounced value `a`/`b` updates only after `DEBOUNCE` consecutive equal synchronised samples.
- FSM states: IDLE, ENTER_A, ENTER_AB, ENTER_B, EXIT_B, EXIT_AB, EXIT_A, DENIED, WAIT_CLEAR.
- IDLE:
  - a&!b → DENIED if `full`, else ENTER_A.
  - !a&b → WAIT_CLEAR if `empty`, else EXIT_B.
  - a&b → WAIT_CLEAR (ambiguous).
- ENTER_A: a&b → ENTER_AB; !a&!b → IDLE (car backed out, no pulse); !a&b → WAIT_CLEAR.
- ENTER_AB: !a&b → ENTER_B; a&!b → ENTER_A; !a&!b → IDLE (no pulse).
- ENTER_B: !a&!b → IDLE and raise `increment`; a&b → ENTER_AB; a&!b → WAIT_CLEAR.
- EXIT_B, EXIT_AB, EXIT_A: mirror of the entry states with a↔b swapped. EXIT_A to IDLE on !a&!b raises `decrement`.
- DENIED, WAIT_CLEAR: hold until !a&!b, then → IDLE. No pulse.
- Timeout: a counter of width $clog2(TIMEOUT+1) clears on every state change. If it reaches `TIMEOUT` in any state other than IDLE, DENIED or WAIT_CLEAR, the FSM → WAIT_CLEAR with no pulse.
- `full` and `empty` are sampled only when leaving IDLE. A change during a passage does not affect that passage.

## Timing
- All outputs are registered and change on the same edge as the state register.
- `gate_open` = 1 while the state is one of ENTER_*/EXIT_*. `denied` = 1 while the state is DENIED.
- `increment`/`decrement` are high for exactly one cycle, on the edge that moves ENTER_B/EXIT_A → IDLE.
- `increment` and `decrement` are never high in the same cycle. There is at most one pulse per passage.
- Latency:
  - Raw beam edge → debounced edge: 2 + `DEBOUNCE` cycles.
  - Debounced edge → state/output change: 1 cycle.
- Glitches shorter than `DEBOUNCE` cycles after synchronisation have no effect.
- Reset asserted mid-passage: the passage is dropped and no pulse is issued. After reset deasserts, a beam still broken is seen as a fresh event from IDLE.

## Structure
- Package `garage_pkg`:
  - `lane_state_t` enum.
  - `MAX_CARS` = 50.
  - `CNT_W` = 6 (occupancy width shared with the counter).
- Sub-module `beam_debounce`: synchroniser plus debouncer, parameter `DEBOUNCE`. Instantiated once per beam.
- The top module holds the FSM, the timeout counter and the output registers.

## Test plan
All scenarios use `DEBOUNCE`=4 and `TIMEOUT`=50.
- Reset: `reset`=0 for 2 cycles with both beams broken → all outputs 0 and state IDLE. After release, the FSM goes to WAIT_CLEAR; no pulse ever.
- Full entry: A, then AB, then B, then clear, each held 10 cycles, `full`=0 → `gate_open` high from 7 cycles after A rises. Exactly one `increment` pulse, 7 cycles after B clears. `gate_open` falls on the same edge.
- Exit: B, AB, A, clear, `empty`=0 → one `decrement` pulse, no `increment`.
- Full: `full`=1, A broken → `denied`=1, `gate_open`=0. `denied` drops 7 cycles after A clears; no pulse.
- Back-out and glitch:
  - A, AB, A, clear → no pulse.
  - A 3-cycle pulse on B while idle → no state change.
- Timeout: A held for 60 cycles → `gate_open` falls 50 cycles after entering ENTER_A, state WAIT_CLEAR, no pulse.

Source files
------------

// File: rtl/garage_pkg.sv
// garage_pkg: shared types and constants for the garage lane sensor and the
// occupancy counter that sits downstream of it.
//   lane_state_t : passage-tracking FSM states
//   MAX_CARS     : garage capacity (the counter owns full/empty)
//   CNT_W        : occupancy counter width
package garage_pkg;

  localparam int MAX_CARS = 50;
  localparam int CNT_W    = 6;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    ENTER_A    = 4'd1,
    ENTER_AB   = 4'd2,
    ENTER_B    = 4'd3,
    EXIT_B     = 4'd4,
    EXIT_AB    = 4'd5,
    EXIT_A     = 4'd6,
    DENIED     = 4'd7,
    WAIT_CLEAR = 4'd8
  } lane_state_t;

  // True in the states where a car is actively moving through the lane;
  // these states raise the barrier and are subject to the timeout.
  function automatic logic is_passage(input lane_state_t s);
    return (s == ENTER_A) || (s == ENTER_AB) || (s == ENTER_B) ||
           (s == EXIT_B)  || (s == EXIT_AB)  || (s == EXIT_A);
  endfunction

endpackage

// File: rtl/garage_lane_sensor_if.sv
// garage_lane_sensor_if: bundles the lane-sensor signals.
//   sensor_a/sensor_b : raw beams (1 = broken), asynchronous
//   full/empty        : occupancy status from the counter
//   increment/decrement : one-cycle pulses to the counter
//   gate_open/denied  : barrier command and entry-refused indicator
//   state             : current FSM state, exposed for debug/checkers
// Modport master is the environment side, slave is the sensor block.
interface garage_lane_sensor_if;
  import garage_pkg::*;

  logic        sensor_a;
  logic        sensor_b;
  logic        full;
  logic        empty;
  logic        increment;
  logic        decrement;
  logic        gate_open;
  logic        denied;
  lane_state_t state;

  modport master (
    output sensor_a, sensor_b, full, empty,
    input  increment, decrement, gate_open, denied, state
  );

  modport slave (
    input  sensor_a, sensor_b, full, empty,
    output increment, decrement, gate_open, denied, state
  );

endinterface

// File: rtl/beam_debounce.sv
// beam_debounce: 2-flop synchroniser followed by a debouncer for one beam.
//   clk      : clock
//   reset    : synchronous active-low reset
//   raw_i    : asynchronous raw beam (1 = broken)
//   beam_o   : debounced beam
// The debounced value follows the synchronised value only after DEBOUNCE
// consecutive samples that differ from it, so the raw-to-debounced latency
// is 2 + DEBOUNCE cycles and shorter glitches are ignored.
module beam_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic beam_o
);

  localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          beam_q;
  logic          beam_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // cnt_q counts how many samples in a row have disagreed with beam_q; any
  // agreeing sample restarts the count.
  always_comb begin
    beam_d = beam_q;
    cnt_d  = '0;
    if (sync2_q != beam_q) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) begin
        beam_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      beam_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      beam_q  <= beam_d;
      cnt_q   <= cnt_d;
    end
  end

  assign beam_o = beam_q;

endmodule

// File: rtl/garage_lane_sensor.sv
// garage_lane_sensor: classifies vehicle passages through one bidirectional
// lane from two beams, A (street side) and B (garage side).
//   clk   : clock, rising edge
//   reset : synchronous active-low reset
//   lane  : garage_lane_sensor_if.slave (beams, full/empty in; pulses,
//           gate_open, denied and debug state out)
// An entry is A, AB, B, clear; an exit is B, AB, A, clear. Each completed
// passage produces one registered single-cycle increment or decrement.
// full/empty only matter at the moment a passage starts from IDLE.
module garage_lane_sensor
  import garage_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  garage_lane_sensor_if.slave   lane
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic          a;
  logic          b;
  logic [1:0]    ab;
  lane_state_t   state_q;
  lane_state_t   state_d;
  lane_state_t   beam_next;
  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_d;
  logic          inc_q;
  logic          inc_d;
  logic          dec_q;
  logic          dec_d;
  logic          gate_q;
  logic          gate_d;
  logic          denied_q;
  logic          denied_d;

  beam_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_a (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (lane.sensor_a),
    .beam_o (a)
  );

  beam_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_b (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (lane.sensor_b),
    .beam_o (b)
  );

  assign ab = {a, b};

  // Beam-driven transitions. Patterns not listed keep the current state.
  always_comb begin
    beam_next = state_q;
    case (state_q)
      IDLE: begin
        case (ab)
          2'b10:   beam_next = lane.full  ? DENIED     : ENTER_A;
          2'b01:   beam_next = lane.empty ? WAIT_CLEAR : EXIT_B;
          2'b11:   beam_next = WAIT_CLEAR;
          default: beam_next = IDLE;
        endcase
      end
      ENTER_A: begin
        if (ab == 2'b11)      beam_next = ENTER_AB;
        else if (ab == 2'b00) beam_next = IDLE;
        else if (ab == 2'b01) beam_next = WAIT_CLEAR;
      end
      ENTER_AB: begin
        if (ab == 2'b01)      beam_next = ENTER_B;
        else if (ab == 2'b10) beam_next = ENTER_A;
        else if (ab == 2'b00) beam_next = IDLE;
      end
      ENTER_B: begin
        if (ab == 2'b00)      beam_next = IDLE;
        else if (ab == 2'b11) beam_next = ENTER_AB;
        else if (ab == 2'b10) beam_next = WAIT_CLEAR;
      end
      EXIT_B: begin
        if (ab == 2'b11)      beam_next = EXIT_AB;
        else if (ab == 2'b00) beam_next = IDLE;
        else if (ab == 2'b10) beam_next = WAIT_CLEAR;
      end
      EXIT_AB: begin
        if (ab == 2'b10)      beam_next = EXIT_A;
        else if (ab == 2'b01) beam_next = EXIT_B;
        else if (ab == 2'b00) beam_next = IDLE;
      end
      EXIT_A: begin
        if (ab == 2'b00)      beam_next = IDLE;
        else if (ab == 2'b11) beam_next = EXIT_AB;
        else if (ab == 2'b01) beam_next = WAIT_CLEAR;
      end
      DENIED, WAIT_CLEAR: begin
        if (ab == 2'b00)      beam_next = IDLE;
      end
      default: beam_next = IDLE;
    endcase
  end

  // Timeout: tmo_q counts cycles spent in the current passage state. The
  // abort fires on the edge where the count would reach TIMEOUT, so a stuck
  // passage state lasts exactly TIMEOUT cycles.
  always_comb begin
    state_d = beam_next;
    tmo_d   = '0;
    if (is_passage(state_q) && (beam_next == state_q)) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        state_d = WAIT_CLEAR;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // Outputs are decoded from the next state so they change on the same
  // edge as the state register.
  always_comb begin
    inc_d    = (state_q == ENTER_B) && (state_d == IDLE);
    dec_d    = (state_q == EXIT_A)  && (state_d == IDLE);
    gate_d   = is_passage(state_d);
    denied_d = (state_d == DENIED);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      tmo_q    <= '0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      gate_q   <= 1'b0;
      denied_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      gate_q   <= gate_d;
      denied_q <= denied_d;
    end
  end

  assign lane.increment = inc_q;
  assign lane.decrement = dec_q;
  assign lane.gate_open = gate_q;
  assign lane.denied    = denied_q;
  assign lane.state     = state_q;

endmodule
